// File: rtl/pos_mask_decoder.sv
// Decodes a stream of bit positions into one-hot bits and ORs them into a group mask; result registered 1 cycle after the closing beat.
// Input is stalled only while a finished mask waits on out_ready; draining and accepting in the same cycle is allowed.
module pos_mask_decoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2,
  parameter int GROUP = 4,
  localparam int CNT_W = $clog2(GROUP + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_pos,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic [CNT_W-1:0] out_count,
  output logic             out_dup,
  output logic             out_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dup;
  logic             r_err;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_mask;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_dup;
  logic             r_out_err;

  logic             w_in_ready;
  logic             w_accept;
  logic [31:0]      w_pos_ext;
  logic             w_in_range;
  logic [WIDTH-1:0] w_onehot;
  logic             w_dup_hit;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_close;

  assign w_in_ready = !(r_out_valid && !out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_pos_ext  = 32'(in_pos);
  assign w_in_range = (w_pos_ext < 32'(WIDTH));

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_onehot[i] = (w_pos_ext == 32'(i));
    end
  end

  assign w_dup_hit  = |(w_onehot & r_acc);
  assign w_cnt_next = r_cnt + CNT_W'(1);
  // A group closes on in_last or when this beat fills it to GROUP beats.
  assign w_close    = w_accept && (in_last || (w_cnt_next == CNT_W'(GROUP)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_dup       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_out_count <= '0;
      r_out_dup   <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      if (w_close) begin
        r_state     <= ST_IDLE;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_dup       <= 1'b0;
        r_err       <= 1'b0;
        r_out_valid <= 1'b1;
        r_out_mask  <= r_acc | w_onehot;
        r_out_count <= w_cnt_next;
        r_out_dup   <= r_dup | w_dup_hit;
        r_out_err   <= r_err | !w_in_range;
      end else begin
        if (w_accept) begin
          r_state <= ST_ACCUM;
          r_acc   <= r_acc | w_onehot;
          r_cnt   <= w_cnt_next;
          r_dup   <= r_dup | w_dup_hit;
          r_err   <= r_err | !w_in_range;
        end
        // Fields are left as-is after a drain; out_valid alone qualifies them.
        if (r_out_valid && out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_mask  = r_out_mask;
  assign out_count = r_out_count;
  assign out_dup   = r_out_dup;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_pos_mask_decoder.sv
// Directed bench for pos_mask_decoder: table of per-cycle vectors on a 4-bit instance,
// plus hand sequences for mid-group reset and out-of-range positions on a 3-bit instance.
module tb_pos_mask_decoder;

  typedef struct packed {
    logic       v;
    logic [1:0] pos;
    logic       last;
    logic       ordy;
    logic       e_rdy;
    logic       e_ov;
    logic [3:0] e_mask;
    logic [2:0] e_cnt;
    logic       e_dup;
    logic       e_err;
  } vec_t;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, in_last, out_valid, out_ready, out_dup, out_err;
  logic [1:0] in_pos;
  logic [3:0] out_mask;
  logic [2:0] out_count;

  logic       in_valid3, in_ready3, in_last3, out_valid3, out_ready3, out_dup3, out_err3;
  logic [1:0] in_pos3;
  logic [2:0] out_mask3;
  logic [2:0] out_count3;

  int n_cmp;
  int n_err;
  vec_t vt [19];

  pos_mask_decoder #(.WIDTH(4), .IDX_W(2), .GROUP(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_count(out_count), .out_dup(out_dup), .out_err(out_err)
  );

  pos_mask_decoder #(.WIDTH(3), .IDX_W(2), .GROUP(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_pos(in_pos3), .in_last(in_last3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_mask(out_mask3),
    .out_count(out_count3), .out_dup(out_dup3), .out_err(out_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v, input int pos, input int last, input int ordy,
                              input int e_rdy, input int e_ov, input int e_mask,
                              input int e_cnt, input int e_dup, input int e_err);
    vec_t r;
    r.v      = 1'(v);
    r.pos    = 2'(pos);
    r.last   = 1'(last);
    r.ordy   = 1'(ordy);
    r.e_rdy  = 1'(e_rdy);
    r.e_ov   = 1'(e_ov);
    r.e_mask = 4'(e_mask);
    r.e_cnt  = 3'(e_cnt);
    r.e_dup  = 1'(e_dup);
    r.e_err  = 1'(e_err);
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    // Expected columns describe outputs seen before the edge that applies the row's inputs.
    //          v pos last ordy | rdy ov mask  cnt dup err
    vt[0]  = mk(0, 0, 0, 1,       1,  0, 'h0, 0,  0,  0);
    vt[1]  = mk(1, 2, 1, 1,       1,  0, 'h0, 0,  0,  0);
    vt[2]  = mk(0, 0, 0, 1,       1,  1, 'h4, 1,  0,  0);
    vt[3]  = mk(1, 0, 0, 1,       1,  0, 'h4, 1,  0,  0);
    vt[4]  = mk(1, 1, 0, 1,       1,  0, 'h4, 1,  0,  0);
    vt[5]  = mk(1, 3, 0, 1,       1,  0, 'h4, 1,  0,  0);
    vt[6]  = mk(1, 1, 0, 1,       1,  0, 'h4, 1,  0,  0);
    vt[7]  = mk(1, 2, 1, 1,       1,  1, 'hB, 4,  1,  0);
    vt[8]  = mk(1, 0, 1, 0,       0,  1, 'h4, 1,  0,  0);
    vt[9]  = mk(1, 0, 1, 0,       0,  1, 'h4, 1,  0,  0);
    vt[10] = mk(1, 0, 1, 1,       1,  1, 'h4, 1,  0,  0);
    vt[11] = mk(1, 3, 1, 1,       1,  1, 'h1, 1,  0,  0);
    vt[12] = mk(0, 0, 0, 1,       1,  1, 'h8, 1,  0,  0);
    vt[13] = mk(1, 1, 0, 1,       1,  0, 'h8, 1,  0,  0);
    vt[14] = mk(1, 1, 1, 1,       1,  0, 'h8, 1,  0,  0);
    vt[15] = mk(0, 0, 0, 0,       0,  1, 'h2, 2,  1,  0);
    vt[16] = mk(0, 0, 0, 0,       0,  1, 'h2, 2,  1,  0);
    vt[17] = mk(0, 0, 0, 1,       1,  1, 'h2, 2,  1,  0);
    vt[18] = mk(0, 0, 0, 1,       1,  0, 'h2, 2,  1,  0);

    rst_n = 1'b0;
    in_valid = 1'b0; in_pos = 2'd0; in_last = 1'b0; out_ready = 1'b1;
    in_valid3 = 1'b0; in_pos3 = 2'd0; in_last3 = 1'b0; out_ready3 = 1'b1;
    next_cycle();
    next_cycle();
    chk("rst3_out_valid", 32'(out_valid3), 32'd0);
    chk("rst3_out_mask", 32'(out_mask3), 32'd0);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 19; i++) begin
      in_valid  = vt[i].v;
      in_pos    = vt[i].pos;
      in_last   = vt[i].last;
      out_ready = vt[i].ordy;
      #3;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("v%0d_out_mask", i), 32'(out_mask), 32'(vt[i].e_mask));
      chk($sformatf("v%0d_out_count", i), 32'(out_count), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d_out_dup", i), 32'(out_dup), 32'(vt[i].e_dup));
      chk($sformatf("v%0d_out_err", i), 32'(out_err), 32'(vt[i].e_err));
      next_cycle();
    end

    // Reset in the middle of an open group discards the partial mask.
    in_valid = 1'b1; in_pos = 2'd2; in_last = 1'b0; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_mask", 32'(out_mask), 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    chk("midrst_out_dup", 32'(out_dup), 32'd0);
    chk("midrst_out_err", 32'(out_err), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    in_valid = 1'b1; in_pos = 2'd0; in_last = 1'b1;
    next_cycle();
    in_valid = 1'b0; in_last = 1'b0;
    #3;
    chk("postrst_out_valid", 32'(out_valid), 32'd1);
    chk("postrst_out_mask", 32'(out_mask), 32'h1);
    chk("postrst_out_count", 32'(out_count), 32'd1);
    chk("postrst_out_dup", 32'(out_dup), 32'd0);
    next_cycle();

    // Out-of-range position on the 3-bit instance sets err but no mask bit.
    in_valid3 = 1'b1; in_pos3 = 2'd3; in_last3 = 1'b0; out_ready3 = 1'b1;
    next_cycle();
    chk("oor_mid_out_valid", 32'(out_valid3), 32'd0);
    in_pos3 = 2'd1; in_last3 = 1'b1;
    next_cycle();
    in_valid3 = 1'b0; in_last3 = 1'b0;
    #3;
    chk("oor_out_valid", 32'(out_valid3), 32'd1);
    chk("oor_out_mask", 32'(out_mask3), 32'h2);
    chk("oor_out_count", 32'(out_count3), 32'd2);
    chk("oor_out_err", 32'(out_err3), 32'd1);
    chk("oor_out_dup", 32'(out_dup3), 32'd0);
    next_cycle();
    #3;
    chk("oor_drained", 32'(out_valid3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
